// File: rtl/ysyx_22040759_ifu_if.sv
// ysyx_22040759_ifu_if
//   Groups the fetch unit's handshake ports: the instruction-memory request and
//   response channel, the instruction hand-off to decode, and the redirect input
//   from execute.
//   master : the fetch unit (drives requests, instructions, fetch_misalign)
//   slave  : the environment (memory, decode, execute)
//
//   imem_req_valid/ready/addr : one-word fetch request, addr is the PC
//   imem_rsp_valid/data       : fetched word; memory never back-pressures it
//   inst_valid/ready, inst_o, pc_o : buffered instruction and its PC to decode
//   redirect_valid/pc         : one-cycle PC change from execute
//   fetch_misalign            : misaligned redirect target trapped
interface ysyx_22040759_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_misalign;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_o, pc_o, fetch_misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_o, pc_o, fetch_misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22040759_ifu.sv
// ysyx_22040759_ifu
//   Instruction fetch unit. Owns the PC, issues one word fetch at a time to
//   instruction memory, buffers the returned word and hands it with its PC to
//   decode. A redirect from execute reloads the PC and throws away any fetch
//   it made stale; a response for a request already in flight is swallowed
//   via the drop flag.
//
//   Ports: clk, rst_n (async, active low) and bus (ysyx_22040759_ifu_if.master).
//   Parameter RESET_PC: PC of the first fetch after reset.
//
//   Build option YSYX_22040759_IFU_MISALIGN_EN: when defined, a redirect to a
//   non word-aligned target parks the unit in TRAP with fetch_misalign high
//   until an aligned redirect arrives. When undefined, the low two target bits
//   are cleared and fetch_misalign is tied low.
module ysyx_22040759_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ysyx_22040759_ifu_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3
`ifdef YSYX_22040759_IFU_MISALIGN_EN
        ,
        S_TRAP = 3'd4
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        drop_q, drop_d;

    logic [63:0] redir_pc;
    logic        in_flight;
    logic        req_valid;
    logic        inst_valid;
    logic        misalign;

`ifdef YSYX_22040759_IFU_MISALIGN_EN
    logic        redir_misalign;
    assign redir_pc       = bus.redirect_pc;
    assign redir_misalign = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc       = bus.redirect_pc & ~64'h3;
`endif

    // A request is still owed a response after this edge: it is being
    // accepted now, or it is outstanding and its response is not here yet.
    always_comb begin
        in_flight = 1'b0;
        case (state_q)
            S_REQ:   in_flight = bus.imem_req_ready;
            S_WAIT:  in_flight = !bus.imem_rsp_valid;
`ifdef YSYX_22040759_IFU_MISALIGN_EN
            S_TRAP:  in_flight = drop_q && !bus.imem_rsp_valid;
`endif
            default: in_flight = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_buf_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic; a redirect overrides the normal flow everywhere but IDLE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        drop_d     = drop_q;
        if (state_q != S_IDLE && bus.redirect_valid) begin
            pc_d   = redir_pc;
            // Any request still owed a response must have that response eaten.
            drop_d = in_flight;
`ifdef YSYX_22040759_IFU_MISALIGN_EN
            if (redir_misalign)  state_d = S_TRAP;
            else if (in_flight)  state_d = S_WAIT;
            else                 state_d = S_REQ;
`else
            state_d = in_flight ? S_WAIT : S_REQ;
`endif
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (bus.imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_buf_d = bus.imem_rsp_data;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.inst_ready) begin
                        pc_d    = pc_q + 64'd4;
                        state_d = S_REQ;
                    end
                end
`ifdef YSYX_22040759_IFU_MISALIGN_EN
                // Parked; only soak up a stale response still on its way.
                S_TRAP: begin
                    if (drop_q && bus.imem_rsp_valid) drop_d = 1'b0;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
        misalign   = 1'b0;
        case (state_q)
            S_REQ:   req_valid  = 1'b1;
            S_HOLD:  inst_valid = 1'b1;
`ifdef YSYX_22040759_IFU_MISALIGN_EN
            S_TRAP:  misalign   = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_o         = inst_buf_q;
    assign bus.pc_o           = pc_q;
    assign bus.fetch_misalign = misalign;

endmodule
